// File: rtl/alu_scheduler.sv
// Round-robin scheduler that shares one combinational ALU between two requesters.
// Operands are registered toward the ALU, and one tagged result is returned at a time with valid/ready handshaking.
module alu_scheduler #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [WIDTH-1:0] req0_data1_i,
    input  logic [WIDTH-1:0] req0_data2_i,
    input  logic [2:0]       req0_ctrl_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [WIDTH-1:0] req1_data1_i,
    input  logic [WIDTH-1:0] req1_data2_i,
    input  logic [2:0]       req1_ctrl_i,
    output logic [WIDTH-1:0] alu_data1_o,
    output logic [WIDTH-1:0] alu_data2_o,
    output logic [2:0]       alu_ctrl_o,
    input  logic [WIDTH-1:0] alu_data_i,
    input  logic             alu_zero_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic             resp_id_o,
    output logic [WIDTH-1:0] resp_data_o,
    output logic             resp_zero_o,
    output logic             resp_err_o,
    output logic             busy_o
);

    localparam int               CNT_W   = $clog2(MUL_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(MUL_CYCLES - 1);
    localparam logic [2:0]       OP_ADD  = 3'b000;
    localparam logic [2:0]       OP_SUB  = 3'b010;
    localparam logic [2:0]       OP_MUL  = 3'b011;
    localparam logic [2:0]       OP_ILL  = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_r;
    logic             prio_r;
    logic [CNT_W-1:0] cnt_r;

    logic             grant_s;
    logic             rdy0_s;
    logic             rdy1_s;
    logic             accept_s;
    logic [WIDTH-1:0] sel_data1_s;
    logic [WIDTH-1:0] sel_data2_s;
    logic [2:0]       sel_ctrl_s;

    // Arbitration: a lone valid requester wins; when both are valid, prio breaks the tie.
    always_comb begin
        grant_s     = 1'b0;
        sel_data1_s = req0_data1_i;
        sel_data2_s = req0_data2_i;
        sel_ctrl_s  = req0_ctrl_i;
        if (req0_valid_i && req1_valid_i) begin
            grant_s = prio_r;
        end else if (req1_valid_i) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        if (grant_s) begin
            sel_data1_s = req1_data1_i;
            sel_data2_s = req1_data2_i;
            sel_ctrl_s  = req1_ctrl_i;
        end else begin
            sel_data1_s = req0_data1_i;
            sel_data2_s = req0_data2_i;
            sel_ctrl_s  = req0_ctrl_i;
        end
        rdy0_s   = (state_r == IDLE) && req0_valid_i && !grant_s;
        rdy1_s   = (state_r == IDLE) && req1_valid_i && grant_s;
        accept_s = rdy0_s || rdy1_s;
    end

    assign req0_ready_o = rdy0_s;
    assign req1_ready_o = rdy1_s;
    assign resp_valid_o = (state_r == RESP);
    assign busy_o       = (state_r != IDLE);

    // Scheduler FSM: holds the ALU operands, counts down the MUL path, and parks the result until it is taken.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r     <= IDLE;
            prio_r      <= 1'b0;
            cnt_r       <= '0;
            alu_data1_o <= '0;
            alu_data2_o <= '0;
            alu_ctrl_o  <= OP_ADD;
            resp_id_o   <= 1'b0;
            resp_data_o <= '0;
            resp_zero_o <= 1'b0;
            resp_err_o  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        alu_data1_o <= sel_data1_s;
                        alu_data2_o <= sel_data2_s;
                        alu_ctrl_o  <= sel_ctrl_s;
                        resp_id_o   <= grant_s;
                        prio_r      <= ~grant_s;
                        if (sel_ctrl_s == OP_ILL) begin
                            state_r     <= RESP;
                            cnt_r       <= '0;
                            resp_err_o  <= 1'b1;
                            resp_data_o <= '0;
                            resp_zero_o <= 1'b0;
                        end else begin
                            state_r <= EXEC;
                            cnt_r   <= (sel_ctrl_s == OP_MUL) ? CNT_MUL : '0;
                        end
                    end
                end
                EXEC: begin
                    if (cnt_r == '0) begin
                        resp_data_o <= alu_data_i;
                        resp_zero_o <= (alu_ctrl_o == OP_SUB) ? alu_zero_i : 1'b0;
                        resp_err_o  <= 1'b0;
                        state_r     <= RESP;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler: directed vector table, corner sequences and randomized ops.
// Expected results come from a behavioural ALU model applied to the requested operands.
module tb_alu_scheduler;

    localparam int W  = 32;
    localparam int MC = 4;

    logic         clk = 1'b0;
    logic         rst_i = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready_o, req1_ready_o;
    logic [W-1:0] req0_d1 = '0, req0_d2 = '0, req1_d1 = '0, req1_d2 = '0;
    logic [2:0]   req0_op = 3'b000, req1_op = 3'b000;
    logic [W-1:0] alu_data1_o, alu_data2_o, alu_res, resp_data_o;
    logic [2:0]   alu_ctrl_o;
    logic         alu_zero, resp_valid_o, resp_id_o, resp_zero_o, resp_err_o, busy_o;
    logic         resp_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit         id;
        logic [2:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_data;
        logic       exp_zero;
        logic       exp_err;
        int         exp_lat;
        int         hold;
    } vec_t;

    vec_t tbl[11];

    alu_scheduler #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready_o),
        .req0_data1_i(req0_d1), .req0_data2_i(req0_d2), .req0_ctrl_i(req0_op),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready_o),
        .req1_data1_i(req1_d1), .req1_data2_i(req1_d2), .req1_ctrl_i(req1_op),
        .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_ctrl_o(alu_ctrl_o),
        .alu_data_i(alu_res), .alu_zero_i(alu_zero),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready),
        .resp_id_o(resp_id_o), .resp_data_o(resp_data_o),
        .resp_zero_o(resp_zero_o), .resp_err_o(resp_err_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            3'b000:  r = a + b;
            3'b001:  r = a << b[4:0];
            3'b010:  r = a - b;
            3'b011:  r = a * b;
            3'b100:  r = a ^ b;
            3'b101:  r = $signed(a) >>> b[4:0];
            3'b111:  r = a & b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // The shared ALU sits outside the scheduler, so the bench provides it.
    always_comb begin
        alu_res  = model(alu_ctrl_o, alu_data1_o, alu_data2_o);
        alu_zero = (alu_res == '0);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_req(input bit id, input logic v, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (id) begin
            req1_valid = v; req1_op = op; req1_d1 = a; req1_d2 = b;
        end else begin
            req0_valid = v; req0_op = op; req0_d1 = a; req0_d2 = b;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b1;
    endtask

    task automatic run_op(input string nm, input bit id, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ed, input logic ez, input logic ee,
                          input int elat, input int hold);
        int  lat;
        bit  got;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        drive_req(id, 1'b1, op, a, b);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = id ? req1_ready_o : req0_ready_o;
        end
        if (!got) begin
            chk({nm, "_ready_timeout"}, 64'(0), 64'(1));
            drive_req(id, 1'b0, op, a, b);
            return;
        end
        @(posedge clk); #1;
        drive_req(id, 1'b0, ~op, $urandom, $urandom);
        got = 1'b0;
        lat = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            lat++;
            got = resp_valid_o;
            if (!got) chk({nm, "_exec_hold"}, {busy_o, alu_ctrl_o, alu_data1_o, alu_data2_o}, {1'b1, op, a, b});
        end
        chk({nm, "_latency"}, 64'(lat), 64'(elat));
        chk({nm, "_data"}, 64'(resp_data_o), 64'(ed));
        chk({nm, "_zero_err_id"}, {resp_zero_o, resp_err_o, resp_id_o}, {ez, ee, id});
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({nm, "_backpressure"}, {resp_valid_o, req0_ready_o, req1_ready_o, resp_data_o},
                {1'b1, 1'b0, 1'b0, ed});
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk({nm, "_idle_after"}, {busy_o, resp_valid_o}, 2'b00);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        bit           got;
        int           lat;
        int           g_id[$], g_cyc[$], r_id[$];
        logic [W-1:0] r_data[$];
        logic         r_zero[$];
        int           cyc;

        tbl[0]  = '{1'b0, 3'b000, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 2,      0};
        tbl[1]  = '{1'b1, 3'b011, 32'd6,          32'd7,          32'd42,         1'b0, 1'b0, 1 + MC, 0};
        tbl[2]  = '{1'b0, 3'b010, 32'd9,          32'd9,          32'd0,          1'b1, 1'b0, 2,      0};
        tbl[3]  = '{1'b1, 3'b010, 32'd9,          32'd4,          32'd5,          1'b0, 1'b0, 2,      1};
        tbl[4]  = '{1'b0, 3'b110, 32'd1,          32'd2,          32'd0,          1'b0, 1'b1, 1,      2};
        tbl[5]  = '{1'b0, 3'b000, 32'd0,          32'd0,          32'd0,          1'b0, 1'b0, 2,      0};
        tbl[6]  = '{1'b1, 3'b001, 32'd1,          32'd31,         32'h8000_0000,  1'b0, 1'b0, 2,      0};
        tbl[7]  = '{1'b0, 3'b101, 32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0, 1'b0, 2,      0};
        tbl[8]  = '{1'b1, 3'b111, 32'hFF00_FF00,  32'h0FF0_0FF0,  32'h0F00_0F00,  1'b0, 1'b0, 2,      0};
        tbl[9]  = '{1'b0, 3'b011, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  1'b0, 1'b0, 1 + MC, 0};
        tbl[10] = '{1'b1, 3'b100, 32'h0000_000F,  32'h0000_0001,  32'h0000_000E,  1'b0, 1'b0, 2,      0};

        // Reset state.
        #12;
        chk("reset_outputs", {busy_o, resp_valid_o, resp_id_o, resp_zero_o, resp_err_o, resp_data_o,
                              alu_ctrl_o, alu_data1_o, alu_data2_o}, '0);
        do_reset();

        // Vector table.
        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp_data,
                   tbl[i].exp_zero, tbl[i].exp_err, tbl[i].exp_lat, tbl[i].hold);
        end

        // Backpressure with a requester waiting, then the earliest next accept.
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 3'b000, 32'd10, 32'd20);
        @(negedge clk);
        chk("bp_ready0", {req0_ready_o, req1_ready_o}, 2'b10);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 3'b000, '0, '0);
        drive_req(1'b1, 1'b1, 3'b111, 32'hF0, 32'h3C);
        @(negedge clk);
        @(negedge clk);
        chk("bp_first_resp", {resp_valid_o, resp_data_o}, {1'b1, 32'd30});
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            chk("bp_hold", {resp_valid_o, req0_ready_o, req1_ready_o, resp_data_o}, {1'b1, 1'b0, 1'b0, 32'd30});
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_no_accept_in_resp", {resp_valid_o, req1_ready_o}, 2'b10);
        @(posedge clk); #1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk("bp_next_accept", {resp_valid_o, req1_ready_o}, 2'b01);
        @(posedge clk); #1;
        drive_req(1'b1, 1'b0, 3'b000, '0, '0);
        @(negedge clk);
        @(negedge clk);
        chk("bp_second_resp", {resp_valid_o, resp_id_o, resp_data_o}, {1'b1, 1'b1, 32'h30});
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;

        // Randomized ops against the behavioural model.
        for (int i = 0; i < 40; i++) begin
            bit           id;
            logic [2:0]   op;
            logic [W-1:0] a, b, ed;
            id = 1'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            ed = (op == 3'b110) ? '0 : model(op, a, b);
            run_op($sformatf("rnd%0d", i), id, op, a, b, ed, (op == 3'b010) && (ed == '0),
                   op == 3'b110, (op == 3'b110) ? 1 : ((op == 3'b011) ? 1 + MC : 2),
                   $urandom_range(0, 2));
        end

        // Reset in the second EXEC cycle of a MUL.
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 3'b011, 32'd3, 32'd4);
        @(negedge clk);
        chk("mr_ready", 64'(req0_ready_o), 64'(1));
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 3'b000, '0, '0);
        @(posedge clk); #2;
        rst_i = 1'b0;
        #1;
        chk("mr_async_reset", {busy_o, resp_valid_o, alu_ctrl_o, alu_data1_o, alu_data2_o}, '0);
        @(posedge clk); #1;
        rst_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("mr_no_resp", {busy_o, resp_valid_o}, 2'b00);
        end
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 3'b000, 32'd1, 32'd1);
        drive_req(1'b1, 1'b1, 3'b000, 32'd2, 32'd2);
        @(negedge clk);
        chk("mr_tie_grant0", {req0_ready_o, req1_ready_o}, 2'b10);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 3'b000, '0, '0);
        drive_req(1'b1, 1'b0, 3'b000, '0, '0);
        got = 1'b0;
        lat = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            lat++;
            got = resp_valid_o;
        end
        chk("mr_tie_resp", {resp_id_o, resp_data_o, 32'(lat)}, {1'b0, 32'd2, 32'd2});
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;

        // Round-robin with both requesters permanently valid.
        do_reset();
        drive_req(1'b0, 1'b1, 3'b010, 32'd3, 32'd3);
        drive_req(1'b1, 1'b1, 3'b100, 32'hF, 32'h1);
        resp_ready = 1'b1;
        cyc = 0;
        for (int k = 0; k < 60 && r_id.size() < 4; k++) begin
            @(negedge clk);
            cyc++;
            if (req0_ready_o) begin g_id.push_back(0); g_cyc.push_back(cyc); end
            if (req1_ready_o) begin g_id.push_back(1); g_cyc.push_back(cyc); end
            if (resp_valid_o) begin
                r_id.push_back(int'(resp_id_o));
                r_data.push_back(resp_data_o);
                r_zero.push_back(resp_zero_o);
            end
        end
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 3'b000, '0, '0);
        drive_req(1'b1, 1'b0, 3'b000, '0, '0);
        resp_ready = 1'b0;
        chk("rr_counts", {32'(g_id.size()), 32'(r_id.size())}, {32'd4, 32'd4});
        for (int i = 0; i < 4 && i < g_id.size() && i < r_id.size(); i++) begin
            chk($sformatf("rr_grant%0d", i), 64'(g_id[i]), 64'(i % 2));
            if (i > 0) chk($sformatf("rr_period%0d", i), 64'(g_cyc[i] - g_cyc[i-1]), 64'(3));
            chk($sformatf("rr_resp%0d", i), {32'(r_id[i]), r_data[i], 31'd0, r_zero[i]},
                (i % 2 == 0) ? {32'd0, 32'd0, 31'd0, 1'b1} : {32'd1, 32'hE, 31'd0, 1'b0});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
